// File: rtl/haz_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : haz_pkg                                                 |
// | Description: Hazard codes, sequencer states and pipeline control     |
// |              bundle shared by pipe_stage_ctrl and its sub-blocks.    |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package haz_pkg;

  // Hazard classification produced by HazardUnit
  localparam logic [1:0] HAZ_NONE = 2'd0;
  localparam logic [1:0] HAZ_DATA = 2'd1;
  localparam logic [1:0] HAZ_CTRL = 2'd2;
  localparam logic [1:0] HAZ_MISS = 2'd3;

  // Control word loaded into ID/EX when a bubble is inserted
  localparam logic [5:0] NOP_CTRL = 6'b111111;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MISS_REQ  = 2'd1,
    ST_MISS_WAIT = 2'd2,
    ST_RESUME    = 2'd3
  } state_t;

  // Per-stage controls, MSB first in pipeline order
  typedef struct packed {
    logic pc_wen;
    logic if_id_wen;
    logic if_id_flush;
    logic id_ex_wen;
    logic id_ex_bubble;
    logic ex_mem_wen;
    logic mem_wb_wen;
    logic mem_wb_bubble;
    logic refill_req;
  } ctrl_t;

  // True when an ID/EX control word is the bubble pattern
  function automatic logic is_nop_ctrl(input logic [5:0] ctrl);
    return ctrl == NOP_CTRL;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_stage_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface  : pipe_stage_ctrl_if                                      |
// | Description: Hazard input, refill handshake and per-stage controls   |
// |              between HazardUnit/memory side and pipe_stage_ctrl.     |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
interface pipe_stage_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [1:0]       hazType;
  logic             refillGnt;
  logic             refillDone;
  logic             pcWen;
  logic             IF_ID_wen;
  logic             IF_ID_flush;
  logic             ID_EX_wen;
  logic             ID_EX_bubble;
  logic             EX_MEM_wen;
  logic             MEM_WB_wen;
  logic             MEM_WB_bubble;
  logic             refillReq;
  logic             stallErr;
  logic             missErr;
  logic [CNT_W-1:0] stallCnt;
  logic [CNT_W-1:0] flushCnt;
  logic [CNT_W-1:0] missCnt;

  modport master (
    output hazType, refillGnt, refillDone,
    input  pcWen, IF_ID_wen, IF_ID_flush, ID_EX_wen, ID_EX_bubble,
           EX_MEM_wen, MEM_WB_wen, MEM_WB_bubble, refillReq,
           stallErr, missErr, stallCnt, flushCnt, missCnt
  );

  modport slave (
    input  hazType, refillGnt, refillDone,
    output pcWen, IF_ID_wen, IF_ID_flush, ID_EX_wen, ID_EX_bubble,
           EX_MEM_wen, MEM_WB_wen, MEM_WB_bubble, refillReq,
           stallErr, missErr, stallCnt, flushCnt, missCnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_stage_ctrl_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : sat_counter                                             |
// | Description: Up counter with enable and synchronous clear that       |
// |              sticks at all-ones instead of wrapping.                 |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             clr,
  input  wire logic             en,
  output logic      [WIDTH-1:0] count
);

  // Clear wins over enable; the count holds once it reaches all-ones
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : pipe_stage_ctrl                                         |
// | Description: Turns hazType into per-stage enable/flush/bubble        |
// |              controls, runs the cache-miss refill handshake and the  |
// |              data-stall / miss-timeout watchdogs.                    |
// |              Define HAZ_PERF_EN to build the performance counters.   |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module pipe_stage_ctrl
  import haz_pkg::*;
#(
  parameter int STALL_MAX    = 16,
  parameter int MISS_TIMEOUT = 255,
  parameter int CNT_W        = 32
) (
  input wire logic          clk,
  input wire logic          rst,
  pipe_stage_ctrl_if.slave  bus
);

  localparam int SW = $clog2(STALL_MAX + 1);
  localparam int TW = $clog2(MISS_TIMEOUT + 1);
  // Counter value during the cycle that makes the count reach the limit
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(MISS_TIMEOUT - 1);

  state_t        r_state;
  state_t        w_next;
  ctrl_t         w_ctrl;
  logic          r_stall_err;
  logic          r_miss_err;
  logic [SW-1:0] w_stall_wd;
  logic [TW-1:0] w_to_cnt;
  logic          w_stall_inc;
  logic          w_stall_clr;
  logic          w_in_wait;
  logic          w_to_hit;

  assign w_stall_inc = (r_state == ST_RUN) && (bus.hazType == HAZ_DATA);
  assign w_stall_clr = (r_state == ST_RUN) && (bus.hazType != HAZ_DATA);
  assign w_in_wait   = (r_state == ST_MISS_WAIT);
  assign w_to_hit    = w_in_wait && (w_to_cnt >= TO_LAST);

  sat_counter #(.WIDTH(SW)) u_stall_wd (
    .clk(clk), .rst(rst), .clr(w_stall_clr), .en(w_stall_inc), .count(w_stall_wd)
  );

  sat_counter #(.WIDTH(TW)) u_miss_to (
    .clk(clk), .rst(rst), .clr(!w_in_wait), .en(w_in_wait), .count(w_to_cnt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // Sticky error flags; a completing refill beats a same-cycle timeout
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_err <= 1'b0;
      r_miss_err  <= 1'b0;
    end else begin
      if (w_stall_inc && (w_stall_wd >= STALL_LAST)) begin
        r_stall_err <= 1'b1;
      end
      if (w_to_hit && !bus.refillDone) begin
        r_miss_err <= 1'b1;
      end
    end
  end

  // Next state and Mealy stage controls
  always_comb begin
    w_next = r_state;
    w_ctrl = '0;
    case (r_state)
      ST_RUN: begin
        w_ctrl.pc_wen     = 1'b1;
        w_ctrl.if_id_wen  = 1'b1;
        w_ctrl.id_ex_wen  = 1'b1;
        w_ctrl.ex_mem_wen = 1'b1;
        w_ctrl.mem_wb_wen = 1'b1;
        case (bus.hazType)
          HAZ_DATA: begin
            w_ctrl.pc_wen       = 1'b0;
            w_ctrl.if_id_wen    = 1'b0;
            w_ctrl.id_ex_bubble = 1'b1;
          end
          HAZ_CTRL: begin
            w_ctrl.if_id_flush = 1'b1;
          end
          HAZ_MISS: begin
            w_ctrl = '0;
            w_next = ST_MISS_REQ;
          end
          default: begin
          end
        endcase
      end
      ST_MISS_REQ: begin
        w_ctrl.refill_req = 1'b1;
        if (bus.refillGnt) begin
          w_next = bus.refillDone ? ST_RESUME : ST_MISS_WAIT;
        end
      end
      ST_MISS_WAIT: begin
        if (bus.refillDone || w_to_hit) begin
          w_next = ST_RESUME;
        end
      end
      ST_RESUME: begin
        // Frozen MEM result was already written back before the miss
        w_ctrl.mem_wb_bubble = 1'b1;
        w_next               = ST_RUN;
      end
      default: begin
        w_next = ST_RUN;
      end
    endcase
  end

  // While reset is held every output reads as idle
  assign bus.pcWen         = w_ctrl.pc_wen        & ~rst;
  assign bus.IF_ID_wen     = w_ctrl.if_id_wen     & ~rst;
  assign bus.IF_ID_flush   = w_ctrl.if_id_flush   & ~rst;
  assign bus.ID_EX_wen     = w_ctrl.id_ex_wen     & ~rst;
  assign bus.ID_EX_bubble  = w_ctrl.id_ex_bubble  & ~rst;
  assign bus.EX_MEM_wen    = w_ctrl.ex_mem_wen    & ~rst;
  assign bus.MEM_WB_wen    = w_ctrl.mem_wb_wen    & ~rst;
  assign bus.MEM_WB_bubble = w_ctrl.mem_wb_bubble & ~rst;
  assign bus.refillReq     = w_ctrl.refill_req    & ~rst;
  assign bus.stallErr      = r_stall_err          & ~rst;
  assign bus.missErr       = r_miss_err           & ~rst;

`ifdef HAZ_PERF_EN
  logic             w_flush_inc;
  logic             w_in_miss;
  logic [CNT_W-1:0] w_perf_stall;
  logic [CNT_W-1:0] w_perf_flush;
  logic [CNT_W-1:0] w_perf_miss;

  assign w_flush_inc = (r_state == ST_RUN) && (bus.hazType == HAZ_CTRL);
  assign w_in_miss   = (r_state != ST_RUN);

  sat_counter #(.WIDTH(CNT_W)) u_perf_stall (
    .clk(clk), .rst(rst), .clr(1'b0), .en(w_stall_inc), .count(w_perf_stall)
  );
  sat_counter #(.WIDTH(CNT_W)) u_perf_flush (
    .clk(clk), .rst(rst), .clr(1'b0), .en(w_flush_inc), .count(w_perf_flush)
  );
  sat_counter #(.WIDTH(CNT_W)) u_perf_miss (
    .clk(clk), .rst(rst), .clr(1'b0), .en(w_in_miss), .count(w_perf_miss)
  );

  assign bus.stallCnt = rst ? {CNT_W{1'b0}} : w_perf_stall;
  assign bus.flushCnt = rst ? {CNT_W{1'b0}} : w_perf_flush;
  assign bus.missCnt  = rst ? {CNT_W{1'b0}} : w_perf_miss;
`else
  assign bus.stallCnt = {CNT_W{1'b0}};
  assign bus.flushCnt = {CNT_W{1'b0}};
  assign bus.missCnt  = {CNT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_pipe_stage_ctrl                                      |
// | Description: Vector-table bench for pipe_stage_ctrl with a queue     |
// |              scoreboard; expected counters follow HAZ_PERF_EN.       |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_pipe_stage_ctrl;
  import haz_pkg::*;

`ifdef HAZ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {pcWen, IF_ID_wen, IF_ID_flush, ID_EX_wen, ID_EX_bubble,
  //  EX_MEM_wen, MEM_WB_wen, MEM_WB_bubble, refillReq}
  localparam logic [8:0] C_RUN   = 9'b110101100;
  localparam logic [8:0] C_STALL = 9'b000111100;
  localparam logic [8:0] C_FLUSH = 9'b111101100;
  localparam logic [8:0] C_FRZ   = 9'b000000000;
  localparam logic [8:0] C_REQ   = 9'b000000001;
  localparam logic [8:0] C_RES   = 9'b000000010;

  // pc: which perf counter this cycle should advance (0 none, 1 stall, 2 flush, 3 miss)
  typedef struct {
    string      nm;
    bit         r;
    logic [1:0] h;
    bit         g;
    bit         d;
    logic [8:0] c;
    bit         se;
    bit         me;
    int         pc;
  } vec_t;

  logic clk;
  logic rst;
  vec_t tbl[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_stall = 0;
  int   m_flush = 0;
  int   m_miss  = 0;

  pipe_stage_ctrl_if #(.CNT_W(32)) bus ();

  pipe_stage_ctrl #(
    .STALL_MAX(16), .MISS_TIMEOUT(8), .CNT_W(32)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL sim_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  function automatic vec_t mk(string nm, bit r, logic [1:0] h, bit g, bit d,
                              logic [8:0] c, bit se, bit me, int pc);
    vec_t v;
    v.nm = nm; v.r = r; v.h = h; v.g = g; v.d = d;
    v.c = c; v.se = se; v.me = me; v.pc = pc;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one cycle, queue its expectation, compare mid-cycle, advance
  task automatic run_row(input vec_t v);
    vec_t       e;
    logic [8:0] act;
    int         xs, xf, xm;
    rst            = v.r;
    bus.hazType    = v.h;
    bus.refillGnt  = v.g;
    bus.refillDone = v.d;
    sb.push_back(v);
    @(negedge clk);
    e   = sb.pop_front();
    act = {bus.pcWen, bus.IF_ID_wen, bus.IF_ID_flush, bus.ID_EX_wen,
           bus.ID_EX_bubble, bus.EX_MEM_wen, bus.MEM_WB_wen,
           bus.MEM_WB_bubble, bus.refillReq};
    xs = (PERF && !e.r) ? m_stall : 0;
    xf = (PERF && !e.r) ? m_flush : 0;
    xm = (PERF && !e.r) ? m_miss  : 0;
    chk({e.nm, ".ctrl"},     32'(act),          32'(e.c));
    chk({e.nm, ".stallErr"}, 32'(bus.stallErr), 32'(e.se));
    chk({e.nm, ".missErr"},  32'(bus.missErr),  32'(e.me));
    chk({e.nm, ".stallCnt"}, bus.stallCnt,      32'(xs));
    chk({e.nm, ".flushCnt"}, bus.flushCnt,      32'(xf));
    chk({e.nm, ".missCnt"},  bus.missCnt,       32'(xm));
    if (e.r) begin
      m_stall = 0; m_flush = 0; m_miss = 0;
    end else begin
      case (e.pc)
        1: m_stall++;
        2: m_flush++;
        3: m_miss++;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.hazType    = 2'd0;
    bus.refillGnt  = 1'b0;
    bus.refillDone = 1'b0;

    // Reset, data stall x3, flush, ignored refillDone
    tbl.push_back(mk("rst0",    1'b1, 2'd0, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b0, 0));
    tbl.push_back(mk("rst1",    1'b1, 2'd0, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b0, 0));
    tbl.push_back(mk("run",     1'b0, 2'd0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk("stall3", 1'b0, 2'd1, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0, 1));
    tbl.push_back(mk("run_a",   1'b0, 2'd0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 0));
    tbl.push_back(mk("flush",   1'b0, 2'd2, 1'b0, 1'b0, C_FLUSH, 1'b0, 1'b0, 2));
    tbl.push_back(mk("run_b",   1'b0, 2'd0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 0));
    tbl.push_back(mk("done_run",1'b0, 2'd0, 1'b0, 1'b1, C_RUN,   1'b0, 1'b0, 0));
    // Miss: grant on the third request cycle, done on the fourth wait cycle
    tbl.push_back(mk("miss",    1'b0, 2'd3, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b0, 0));
    tbl.push_back(mk("req1",    1'b0, 2'd1, 1'b0, 1'b0, C_REQ,   1'b0, 1'b0, 3));
    tbl.push_back(mk("req2",    1'b0, 2'd2, 1'b0, 1'b0, C_REQ,   1'b0, 1'b0, 3));
    tbl.push_back(mk("req3_gnt",1'b0, 2'd0, 1'b1, 1'b0, C_REQ,   1'b0, 1'b0, 3));
    tbl.push_back(mk("wait1",   1'b0, 2'd3, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b0, 3));
    tbl.push_back(mk("wait2",   1'b0, 2'd1, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b0, 3));
    tbl.push_back(mk("wait3",   1'b0, 2'd2, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b0, 3));
    tbl.push_back(mk("wait4_dn",1'b0, 2'd0, 1'b0, 1'b1, C_FRZ,   1'b0, 1'b0, 3));
    tbl.push_back(mk("resume",  1'b0, 2'd3, 1'b0, 1'b0, C_RES,   1'b0, 1'b0, 3));
    tbl.push_back(mk("run_c",   1'b0, 2'd0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 0));
    // Minimum penalty: grant and done together in MISS_REQ
    tbl.push_back(mk("miss2",   1'b0, 2'd3, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b0, 0));
    tbl.push_back(mk("req_gd",  1'b0, 2'd0, 1'b1, 1'b1, C_REQ,   1'b0, 1'b0, 3));
    tbl.push_back(mk("resume2", 1'b0, 2'd0, 1'b0, 1'b0, C_RES,   1'b0, 1'b0, 3));
    tbl.push_back(mk("run_d",   1'b0, 2'd0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 0));
    // Miss timeout after 8 wait cycles
    tbl.push_back(mk("rst_to",  1'b1, 2'd0, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b0, 0));
    tbl.push_back(mk("to_miss", 1'b0, 2'd3, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b0, 0));
    tbl.push_back(mk("to_req",  1'b0, 2'd0, 1'b1, 1'b0, C_REQ,   1'b0, 1'b0, 3));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk("to_wait", 1'b0, 2'd0, 1'b0, 1'b0, C_FRZ,  1'b0, 1'b0, 3));
    tbl.push_back(mk("to_res",  1'b0, 2'd0, 1'b0, 1'b0, C_RES,   1'b0, 1'b1, 3));
    tbl.push_back(mk("to_run",  1'b0, 2'd0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b1, 0));
    tbl.push_back(mk("to_flush",1'b0, 2'd2, 1'b0, 1'b0, C_FLUSH, 1'b0, 1'b1, 2));
    // Reset during MISS_WAIT
    tbl.push_back(mk("rm_miss", 1'b0, 2'd3, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b1, 0));
    tbl.push_back(mk("rm_req",  1'b0, 2'd0, 1'b1, 1'b0, C_REQ,   1'b0, 1'b1, 3));
    tbl.push_back(mk("rm_wait1",1'b0, 2'd0, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b1, 3));
    tbl.push_back(mk("rm_wait2",1'b0, 2'd0, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b1, 3));
    tbl.push_back(mk("rm_rst",  1'b1, 2'd0, 1'b0, 1'b0, C_FRZ,   1'b0, 1'b0, 0));
    tbl.push_back(mk("rm_run",  1'b0, 2'd0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 0));
    tbl.push_back(mk("rm_stall",1'b0, 2'd1, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0, 1));
    tbl.push_back(mk("rm_run2", 1'b0, 2'd0, 1'b0, 1'b0, C_RUN,   1'b0, 1'b0, 0));

    foreach (tbl[i]) run_row(tbl[i]);

    // Watchdog: 15-cycle stalls separated by a break never fire
    run_row(mk("wd_rst", 1'b1, 2'd0, 1'b0, 1'b0, C_FRZ, 1'b0, 1'b0, 0));
    for (int k = 0; k < 15; k++)
      run_row(mk("wd_a", 1'b0, 2'd1, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0, 1));
    run_row(mk("wd_brk", 1'b0, 2'd0, 1'b0, 1'b0, C_RUN, 1'b0, 1'b0, 0));
    for (int k = 0; k < 15; k++)
      run_row(mk("wd_b", 1'b0, 2'd1, 1'b0, 1'b0, C_STALL, 1'b0, 1'b0, 1));
    run_row(mk("wd_brk2", 1'b0, 2'd2, 1'b0, 1'b0, C_FLUSH, 1'b0, 1'b0, 2));

    // Watchdog: 17 stall cycles; flag is set by the 16th and stays set
    for (int k = 1; k <= 17; k++)
      run_row(mk("wd_c", 1'b0, 2'd1, 1'b0, 1'b0, C_STALL, (k == 17), 1'b0, 1));
    run_row(mk("wd_hold1", 1'b0, 2'd0, 1'b0, 1'b0, C_RUN, 1'b1, 1'b0, 0));
    run_row(mk("wd_hold2", 1'b0, 2'd0, 1'b0, 1'b0, C_RUN, 1'b1, 1'b0, 0));
    run_row(mk("wd_rst2",  1'b1, 2'd0, 1'b0, 1'b0, C_FRZ, 1'b0, 1'b0, 0));
    run_row(mk("wd_clr",   1'b0, 2'd0, 1'b0, 1'b0, C_RUN, 1'b0, 1'b0, 0));

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
